// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-and-add multiply sequencer that borrows the shared 8-bit ALU from the core.
// Optional build macro ALU_MUL_EARLY_EXIT_EN: stop shifting once no multiplier bits remain.
module alu_mul_seq #(
    parameter int                     BIT_COUNT      = 8,
    parameter logic [BIT_COUNT-1:0]   SHL1_AMT       = 8'h01,
    parameter int                     ALU_MODE_COUNT = 8,
    parameter int                     ALU_MODE_ADD   = 0,
    parameter int                     ALU_MODE_SHIFT = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BIT_COUNT-1:0]      core_a,
    input  logic [BIT_COUNT-1:0]      core_b,
    input  logic [ALU_MODE_COUNT-1:0] core_mode,
    input  logic                      start,
    input  logic [BIT_COUNT-1:0]      op_a,
    input  logic [BIT_COUNT-1:0]      op_b,
    input  logic [BIT_COUNT-1:0]      alu_c,
    output logic [BIT_COUNT-1:0]      alu_a,
    output logic [BIT_COUNT-1:0]      alu_b,
    output logic [ALU_MODE_COUNT-1:0] alu_mode,
    output logic                      busy,
    output logic                      done,
    output logic [BIT_COUNT-1:0]      result
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHL,
        ST_DONE
    } state_t;

    state_t               state_q;
    logic [BIT_COUNT-1:0] mcand_q;
    logic [BIT_COUNT-1:0] mplier_q;
    logic [BIT_COUNT-1:0] prod_q;
    logic [BIT_COUNT-1:0] result_q;
    logic [3:0]           cnt_q;
    logic                 busy_q;
    logic                 done_q;

    logic [BIT_COUNT-1:0] mplier_d;
    logic [3:0]           cnt_d;
    logic                 accept;
    logic                 shl_last;
    logic                 zero_start;

    assign mplier_d = mplier_q >> 1;
    assign cnt_d    = cnt_q + 4'd1;
    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef ALU_MUL_EARLY_EXIT_EN
    assign shl_last   = (cnt_q == 4'd7) || (mplier_d == '0);
    assign zero_start = (op_b == '0);
`else
    assign shl_last   = (cnt_q == 4'd7);
    assign zero_start = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (accept) begin
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        if (zero_start) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= '0;
                        end else begin
                            state_q <= op_b[0] ? ST_ADD : ST_SHL;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    prod_q  <= alu_c;
                    state_q <= ST_SHL;
                    busy_q  <= 1'b1;
                end
                ST_SHL: begin
                    mcand_q  <= alu_c;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (shl_last) begin
                        // SHL never touches prod, so prod_q already holds the final product
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= prod_q;
                    end else begin
                        state_q <= mplier_q[1] ? ST_ADD : ST_SHL;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        alu_a    = core_a;
        alu_b    = core_b;
        alu_mode = core_mode;
        case (state_q)
            ST_ADD: begin
                alu_a                  = prod_q;
                alu_b                  = mcand_q;
                alu_mode               = '0;
                alu_mode[ALU_MODE_ADD] = 1'b1;
            end
            ST_SHL: begin
                alu_a                    = mcand_q;
                alu_b                    = SHL1_AMT;
                alu_mode                 = '0;
                alu_mode[ALU_MODE_SHIFT] = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural ALU closing the loop on alu_c.
// Honours ALU_MUL_EARLY_EXIT_EN when computing expected busy-cycle counts.
module tb_alu_mul_seq;

    localparam int M_ADD   = 0;
    localparam int M_OR    = 3;
    localparam int M_SHIFT = 5;
    localparam int MODES   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       core_a, core_b, op_a, op_b, alu_c, alu_a, alu_b, result;
    logic [MODES-1:0] core_mode, alu_mode;
    logic             start, busy, done;

    alu_mul_seq #(
        .BIT_COUNT(8),
        .SHL1_AMT(8'h01),
        .ALU_MODE_COUNT(MODES),
        .ALU_MODE_ADD(M_ADD),
        .ALU_MODE_SHIFT(M_SHIFT)
    ) dut (
        .clk(clk), .rst(rst),
        .core_a(core_a), .core_b(core_b), .core_mode(core_mode),
        .start(start), .op_a(op_a), .op_b(op_b),
        .alu_c(alu_c), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        alu_c = 8'h00;
        if (alu_mode[M_ADD])        alu_c = alu_a + alu_b;
        else if (alu_mode[M_SHIFT]) alu_c = alu_a << alu_b[2:0];
        else if (alu_mode[M_OR])    alu_c = alu_a | alu_b;
    end

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t             sb[$];
    logic [MODES-1:0] mode_log[$];
    int               errors = 0;
    int               checks = 0;
    int               busy_run = 0;
    int               done_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_cycles(input logic [7:0] b);
        int pc;
        int msb;
        pc  = $countones(b);
        msb = 0;
        for (int i = 0; i < 8; i++) if (b[i]) msb = i;
`ifdef ALU_MUL_EARLY_EXIT_EN
        if (b == 8'h00) return 0;
        return pc + msb + 1;
`else
        return pc + 8;
`endif
    endfunction

    function automatic exp_t mk_exp(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [15:0] p;
        p     = 16'(a) * 16'(b);
        e.res = p[7:0];
        e.cyc = exp_cycles(b);
        return e;
    endfunction

    // Output monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) begin
                busy_run++;
                mode_log.push_back(alu_mode);
                check("busy_onehot", 32'($onehot(alu_mode)), 32'd1);
            end
            if (done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("busy_cycles", 32'(busy_run), 32'(e.cyc));
                end
                busy_run = 0;
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        sb.push_back(mk_exp(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = $urandom_range(0, 255);
        op_b  = $urandom_range(0, 255);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        logic [MODES-1:0] ma, ms, mo;
        logic [MODES-1:0] exp_modes[$];
        int               dcount;

        ma = '0; ma[M_ADD] = 1'b1;
        ms = '0; ms[M_SHIFT] = 1'b1;
        mo = '0; mo[M_OR] = 1'b1;

        rst = 1'b1; start = 1'b0; op_a = 8'h00; op_b = 8'h00;
        core_a = 8'h5A; core_b = 8'hA5; core_mode = ma;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_pass_a", 32'(alu_a), 32'h5A);
        check("rst_pass_mode", 32'(alu_mode), 32'(ma));
        rst = 1'b0;

        // 3*5 with ALU mode sequence
        mode_log.delete();
        issue(8'd3, 8'd5);
        wait_empty();
        exp_modes = '{ma, ms, ms, ma, ms};
`ifndef ALU_MUL_EARLY_EXIT_EN
        for (int i = 0; i < 5; i++) exp_modes.push_back(ms);
`endif
        check("mode_count", 32'(mode_log.size()), 32'(exp_modes.size()));
        for (int i = 0; i < exp_modes.size() && i < mode_log.size(); i++)
            check($sformatf("mode_seq[%0d]", i), 32'(mode_log[i]), 32'(exp_modes[i]));

        issue(8'hFF, 8'hFF);
        wait_empty();
        issue(8'd7, 8'd2);
        wait_empty();
        issue(8'h12, 8'h00);
        wait_empty();
        issue(8'h81, 8'h80);
        wait_empty();

        // start while busy must be ignored
        issue(8'h0B, 8'h0D);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; op_a = 8'h55; op_b = 8'h77;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_empty();

        // back-to-back: start held during the DONE cycle
        issue(8'd4, 8'd4);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        check("b2b_first_done", 32'(done), 32'd1);
        start = 1'b1; op_a = 8'd2; op_b = 8'd3;
        sb.push_back(mk_exp(8'd2, 8'd3));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_empty();

        // reset mid-multiply aborts without done
        core_a = 8'h33; core_b = 8'hCC; core_mode = mo;
        issue(8'd3, 8'd5);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_pass_a", 32'(alu_a), 32'h33);
        check("abort_pass_b", 32'(alu_b), 32'hCC);
        check("abort_pass_mode", 32'(alu_mode), 32'(mo));
        dcount = done_seen;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_seen - dcount), 32'd0);

        // idle pass-through is combinational
        core_mode = mo; core_a = 8'h0F; core_b = 8'hF0;
        #1;
        check("pass_a", 32'(alu_a), 32'h0F);
        check("pass_b", 32'(alu_b), 32'hF0);
        check("pass_mode", 32'(alu_mode), 32'(mo));
        check("pass_alu_c", 32'(alu_c), 32'hFF);

        for (int i = 0; i < 6; i++) begin
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            wait_empty();
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
